// File: rtl/slave_in.sv
// Serial bus slave receive path: deserialises the address/burst header and write beats, then issues mem_we or rd_req.
// Latency: mem_we 21 cycles after the first header bit (+9 per extra beat); slave_ready is low in WRITE/RD_WAIT/DONE, and a master_valid=0 cycle stalls without aborting.
module slave_in #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   master_valid,
    input  logic                   write_en,
    input  logic                   read_en,
    input  logic                   rx_address,
    input  logic                   rx_burst_number,
    input  logic                   rx_data,
    input  logic                   rd_complete,
    output logic                   slave_ready,
    output logic                   rx_done,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   mem_we,
    output logic                   rd_req,
    output logic [BURST_WIDTH-1:0] rd_burst
);
    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_WDATA   = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [BURST_WIDTH:0] BEAT_ONE = (BURST_WIDTH + 1)'(1);

    logic [2:0]             state;
    logic                   is_write;
    logic [CNT_W-1:0]       bit_cnt;
    logic [ADDR_WIDTH-1:0]  addr_sr;
    logic [BURST_WIDTH-1:0] burst_sr;
    logic [DATA_WIDTH-1:0]  data_sr;
    logic [BURST_WIDTH:0]   beats_left;
    logic                   rd_req_q;

    logic                   beat_bit;
    logic [ADDR_WIDTH-1:0]  addr_next;
    logic [BURST_WIDTH-1:0] burst_next;
    logic [DATA_WIDTH-1:0]  data_next;

    assign slave_ready = (state == S_IDLE) || (state == S_HEADER) || (state == S_WDATA);
    assign beat_bit    = master_valid && slave_ready;
    assign mem_we      = (state == S_WRITE);
    assign rx_done     = (state == S_DONE);
    assign rd_req      = rd_req_q;

    // LSB arrives first, so each new bit enters at the top and slides down.
    assign addr_next  = {rx_address, addr_sr[ADDR_WIDTH-1:1]};
    assign burst_next = {rx_burst_number, burst_sr[BURST_WIDTH-1:1]};
    assign data_next  = {rx_data, data_sr[DATA_WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            is_write   <= 1'b0;
            bit_cnt    <= '0;
            addr_sr    <= '0;
            burst_sr   <= '0;
            data_sr    <= '0;
            beats_left <= '0;
            rd_req_q   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rd_burst   <= '0;
        end else begin
            rd_req_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (beat_bit && (write_en ^ read_en)) begin
                        addr_sr  <= addr_next;
                        burst_sr <= burst_next;
                        is_write <= write_en;
                        bit_cnt  <= CNT_W'(1);
                        state    <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (beat_bit) begin
                        addr_sr  <= addr_next;
                        burst_sr <= burst_next;
                        if (bit_cnt == CNT_W'(ADDR_WIDTH - 1)) begin
                            mem_addr   <= addr_next;
                            rd_burst   <= burst_next;
                            // One extra bit so a full-scale burst field still counts its last beat.
                            beats_left <= {1'b0, burst_next} + BEAT_ONE;
                            bit_cnt    <= '0;
                            if (is_write) begin
                                state <= S_WDATA;
                            end else begin
                                state    <= S_RD_WAIT;
                                rd_req_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_WDATA: begin
                    if (beat_bit) begin
                        data_sr <= data_next;
                        if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            mem_wdata <= data_next;
                            bit_cnt   <= '0;
                            state     <= S_WRITE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    beats_left <= beats_left - BEAT_ONE;
                    if (beats_left == BEAT_ONE) begin
                        state <= S_DONE;
                    end else begin
                        mem_addr <= mem_addr + ADDR_WIDTH'(1);
                        state    <= S_WDATA;
                    end
                end
                S_RD_WAIT: begin
                    if (rd_complete) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/slave_in.md
Name: slave_in

Overview:
- Slave-side receive end of the serial system bus. It is the counterpart of the master transmit path, which drives master_valid, write_en/read_en and three 1-bit serial lines: address, burst number and data.
- Deserialises the 12-bit address and burst header, then the 8-bit write-data beats.
- Issues write strobes to the slave's local memory, or a single read request to the slave read-return block.
- Signals completion on rx_done.
- Slave selection and routing are done upstream by the bus mux; this block sees only traffic for its own slave.

Parameters:
- ADDR_WIDTH, 12, address field width (serial bits) and mem_addr width.
- DATA_WIDTH, 8, data beat width (serial bits) and mem_wdata width.
- BURST_WIDTH, 12, burst field width; beats per transfer = burst+1.

Ports:
- clk  input  1  bus clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- master_valid  input  1  master is driving valid serial bits this cycle.
- write_en  input  1  transfer is a write; held for the whole transfer.
- read_en  input  1  transfer is a read; held for the whole transfer.
- rx_address  input  1  serial address, LSB first.
- rx_burst_number  input  1  serial burst count, LSB first, in lockstep with rx_address.
- rx_data  input  1  serial write data, LSB first.
- rd_complete  input  1  one-cycle pulse from the read-return block when the read burst has been sent.
- slave_ready  output  1  slave accepts a serial bit this cycle.
- rx_done  output  1  one-cycle pulse when the transfer is complete.
- mem_addr  output  ADDR_WIDTH  current beat address.
- mem_wdata  output  DATA_WIDTH  assembled write beat.
- mem_we  output  1  one-cycle write strobe.
- rd_req  output  1  one-cycle read request.
- rd_burst  output  BURST_WIDTH  received burst field; valid while rd_req=1 and held afterwards.

Behaviour:
- Bit transfer occurs on any cycle with master_valid=1 and slave_ready=1 (a "beat-bit").
- When master_valid=0, bit counters hold. This is a stall, not an abort.
- slave_ready is decoded from state: 1 in IDLE, HEADER and WDATA; 0 in WRITE, RD_WAIT and DONE.
- Reset is asynchronous. It forces IDLE and clears all registers and counters.
  - Reset values: slave_ready=1, rx_done=0, mem_we=0, rd_req=0, mem_addr=0, mem_wdata=0, rd_burst=0.
  - Reset mid-transfer discards the partial transfer; no mem_we or rd_req is issued.
- IDLE:
  - On a beat-bit with exactly one of write_en/read_en high: shift in address bit 0 and burst bit 0, latch the direction, set bit_cnt=1, go to HEADER.
  - Both enables high or both low: ignore the bits and stay in IDLE.
- HEADER:
  - Shift one address bit and one burst bit per beat-bit.
  - After bit ADDR_WIDTH-1, load mem_addr and rd_burst, load beats_left=burst+1 (BURST_WIDTH+1 bits, so burst=4095 gives 4096 beats), and clear bit_cnt.
  - Write: go to WDATA. Read: go to RD_WAIT with rd_req=1 on the first RD_WAIT cycle only.
- WDATA:
  - Shift rx_data per beat-bit.
  - After bit DATA_WIDTH-1, load mem_wdata and go to WRITE.
- WRITE (1 cycle):
  - mem_we=1 with the current mem_addr and mem_wdata; decrement beats_left.
  - If beats_left becomes 0, go to DONE.
  - Otherwise increment mem_addr modulo 2^ADDR_WIDTH (0xFFF wraps to 0x000) and return to WDATA.
  - The master sees slave_ready=0 for this cycle and holds its current bit.
- RD_WAIT:
  - Serial inputs are ignored.
  - Wait for rd_complete, then go to DONE.
  - rd_complete arriving in the same cycle as rd_req is legal and is honoured.
- DONE (1 cycle): rx_done=1, then return to IDLE.
- Latency, zero stalls:
  - Write burst 0: mem_we in transfer cycle 21 (12 header + 8 data + 1), rx_done in cycle 22.
  - Each further beat adds 9 cycles.
- Enable inputs are sampled only in IDLE. Changes mid-transfer are ignored.

Test Plan:
- Write, addr 0x153, burst 0, data 0xA5, no stalls -> single mem_we with mem_addr=0x153, mem_wdata=0xA5 at transfer cycle 21; rx_done pulse at cycle 22; slave_ready=0 exactly in cycles 21 and 22.
- Write, addr 0xFFF, burst 2, data 0x11/0x22/0x33 -> mem_we at addresses 0xFFF, 0x000, 0x001 with data in order; rx_done once, one cycle after the third mem_we.
- Read, addr 0x0AB, burst 3 -> rd_req pulse one cycle after header bit 11 with mem_addr=0x0AB, rd_burst=3; no mem_we; rd_complete 10 cycles later -> rx_done the next cycle, then slave_ready=1.
- Stall: write as in the first scenario, with master_valid low for 5 cycles after header bit 6 -> identical mem_addr/mem_wdata; mem_we delayed by exactly 5 cycles.
- Reset asserted during WDATA bit 4 -> all outputs return to reset values immediately; no mem_we or rx_done. A following clean write of 0x010/0x5A completes correctly.
- write_en=1 and read_en=1 with master_valid=1 in IDLE for 12 cycles -> state stays IDLE; no rd_req, mem_we or rx_done.
